spi_block_buffer: RTL and testbench

- Sits directly downstream of the SPI slave stage and on the `sclk` domain.
- Deserializes the slave's SDO bit stream into DATA_W-bit blocks and hands each block to the AES core over a valid/ready handshake.
- Accepts the AES result over a second valid/ready handshake and serializes it back to the slave's SDS input.
- Together with the slave, this block forms the full-duplex block transport between the SPI link and the cipher.

---
 rtl/spi_block_buffer.sv | 161 ++++++++++++++++
 tb/tb_spi_block_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_block_buffer.sv
// Full-duplex block buffer between the SPI slave and the AES core, clocked on sclk.
// Define SPI_BUF_LSB_FIRST_EN to shift both paths LSB-first (default MSB-first).
module spi_block_buffer #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              CS,
    input  logic              sdo_in,
    output logic              sds_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] result_in,
    input  logic              result_valid,
    output logic              result_ready,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic {TX_EMPTY, TX_LOADED} tx_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    tx_state_t         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] rx_word;

`ifdef SPI_BUF_LSB_FIRST_EN
    function automatic logic [DATA_W-1:0] rx_shift_in(input logic [DATA_W-1:0] s, input logic b);
        return {b, s[DATA_W-1:1]};
    endfunction
    function automatic logic [DATA_W-1:0] tx_shift_out(input logic [DATA_W-1:0] s);
        return {1'b0, s[DATA_W-1:1]};
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] s);
        return s[0];
    endfunction
`else
    function automatic logic [DATA_W-1:0] rx_shift_in(input logic [DATA_W-1:0] s, input logic b);
        return {s[DATA_W-2:0], b};
    endfunction
    function automatic logic [DATA_W-1:0] tx_shift_out(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], 1'b0};
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] s);
        return s[DATA_W-1];
    endfunction
`endif

    always_ff @(posedge sclk) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            tx_state_q   <= TX_EMPTY;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            tx_shift_q   <= '0;
            tx_cnt_q     <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            tx_shift_q   <= tx_shift_d;
            tx_cnt_q     <= tx_cnt_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        rx_word      = rx_shift_in(rx_shift_q, sdo_in);

        if (data_valid_q && data_ready) data_valid_d = 1'b0;

        // Deasserting CS mid-frame throws away the partial word silently.
        if (CS) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
        end else begin
            rx_shift_d = rx_word;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_d   = CNT_W'(1);
                    rx_state_d = RX_SHIFT;
                end
                RX_SHIFT: begin
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RX_IDLE;
                        // A slot is free if empty or being consumed on this same edge.
                        if (!data_valid_q || data_ready) begin
                            data_out_d   = rx_word;
                            data_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_EMPTY: begin
                if (result_valid) begin
                    tx_shift_d = result_in;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_LOADED;
                end
            end
            TX_LOADED: begin
                // CS high pauses the transmit; it resumes in the next frame.
                if (!CS) begin
                    tx_shift_d = tx_shift_out(tx_shift_q);
                    if (tx_cnt_q == LAST) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_EMPTY;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_EMPTY;
        endcase
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign overrun      = overrun_q;
    assign busy         = (rx_cnt_q != '0);
    assign result_ready = (tx_state_q == TX_EMPTY);
    assign sds_out      = (tx_state_q == TX_LOADED) ? tx_bit(tx_shift_q) : 1'b0;

endmodule

// File: tb/tb_spi_block_buffer.sv
// Directed bench for spi_block_buffer; bit order follows SPI_BUF_LSB_FIRST_EN.
module tb_spi_block_buffer;

    localparam int W = 128;

    logic         sclk = 1'b0;
    logic         reset;
    logic         CS;
    logic         sdo_in;
    logic         sds_out;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic [W-1:0] result_in;
    logic         result_valid;
    logic         result_ready;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int fails  = 0;

    spi_block_buffer #(.DATA_W(W)) dut (
        .sclk(sclk), .reset(reset), .CS(CS), .sdo_in(sdo_in), .sds_out(sds_out),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .result_in(result_in), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 sclk = ~sclk;

    // Wire-order index: i-th bit sent/received maps to this word bit.
    function automatic int wire_pos(input int i);
`ifdef SPI_BUF_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; CS = 1'b1; sdo_in = 1'b0; data_ready = 1'b0;
        result_valid = 1'b0; result_in = '0;
        tick(); tick();
        reset = 1'b1;
    endtask

    // Shift n bits of w onto sdo_in; data_ready is raised only on the last edge if asked.
    task automatic send_bits(input logic [W-1:0] w, input int n, input bit ready_last);
        for (int i = 0; i < n; i++) begin
            CS = 1'b0;
            sdo_in = w[wire_pos(i)];
            data_ready = (i == n - 1) ? ready_last : 1'b0;
            tick();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; CS = 1'b0; data_ready = 1'b0; result_valid = 1'b0; result_in = '0;
        for (int i = 0; i < 3; i++) begin
            sdo_in = i[0];
            tick();
        end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (sds_out !== 1'b0) begin fails++; $display("FAIL reset_sds: got %b expected 0", sds_out); end
        checks++; if (result_ready !== 1'b1) begin fails++; $display("FAIL reset_rready: got %b expected 1", result_ready); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (data_out !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_out); end
        reset = 1'b1; CS = 1'b1;
    endtask

    task automatic test_single_rx();
        logic [W-1:0] a = 128'h00112233445566778899AABBCCDDEEFF;
        do_reset();
        send_bits(a, W - 1, 1'b0);
        checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rx_early_valid: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rx_busy: got %b expected 1", busy); end
        sdo_in = a[wire_pos(W - 1)];
        tick();
        CS = 1'b1;
        checks++; if (data_valid !== 1'b1) begin fails++; $display("FAIL rx_valid: got %b expected 1", data_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rx_busy_end: got %b expected 0", busy); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (data_out !== a || data_valid !== 1'b1) begin
                fails++; $display("FAIL rx_hold%0d: got %h/%b expected %h/1", i, data_out, data_valid, a);
            end
        end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rx_consume: got %b expected 0", data_valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rx_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] a = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        logic [W-1:0] b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_reset();
        send_bits(a, W, 1'b0);
        send_bits(b, W, 1'b0);
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (data_out !== a) begin fails++; $display("FAIL ovr_keep: got %h expected %h", data_out, a); end
        checks++; if (data_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b expected 1", data_valid); end
        do_reset();
        send_bits(a, W, 1'b0);
        send_bits(b, W, 1'b1);
        CS = 1'b1;
        checks++; if (data_out !== b) begin fails++; $display("FAIL b2b_data: got %h expected %h", data_out, b); end
        checks++; if (data_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b expected 1", data_valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_abort();
        do_reset();
        send_bits(128'h0, 50, 1'b0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy: got %b expected 1", busy); end
        CS = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b expected 0", busy); end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b expected 0", data_valid); end
        send_bits({W{1'b1}}, W, 1'b0);
        CS = 1'b1;
        checks++; if (data_out !== {W{1'b1}} || data_valid !== 1'b1) begin
            fails++; $display("FAIL abort_data: got %h/%b expected all-ones/1", data_out, data_valid);
        end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL abort_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_tx();
        logic [W-1:0] r = {1'b1, {(W-2){1'b0}}, 1'b1};
        logic         exp;
        do_reset();
        result_in = r; result_valid = 1'b1;
        tick();
        result_valid = 1'b0; result_in = '0;
        checks++; if (result_ready !== 1'b0) begin fails++; $display("FAIL tx_rready_low: got %b expected 0", result_ready); end
        for (int i = 0; i < W; i++) begin
            exp = r[wire_pos(i)];
            if (i == 64) begin
                CS = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    checks++; if (sds_out !== exp) begin fails++; $display("FAIL tx_pause%0d: got %b expected %b", k, sds_out, exp); end
                end
            end
            checks++; if (sds_out !== exp) begin fails++; $display("FAIL tx_bit%0d: got %b expected %b", i, sds_out, exp); end
            checks++; if (result_ready !== 1'b0) begin fails++; $display("FAIL tx_rready%0d: got %b expected 0", i, result_ready); end
            CS = 1'b0; sdo_in = 1'b0;
            tick();
        end
        CS = 1'b1;
        checks++; if (result_ready !== 1'b1) begin fails++; $display("FAIL tx_done: got %b expected 1", result_ready); end
        checks++; if (sds_out !== 1'b0) begin fails++; $display("FAIL tx_idle_sds: got %b expected 0", sds_out); end
    endtask

    task automatic test_bit_order();
`ifdef SPI_BUF_LSB_FIRST_EN
        logic [W-1:0] first = 128'h1;
`else
        logic [W-1:0] first = {1'b1, {(W-1){1'b0}}};
`endif
        do_reset();
        // Raw wire: a single 1 followed by W-1 zeros.
        for (int i = 0; i < W; i++) begin
            CS = 1'b0; sdo_in = (i == 0); tick();
        end
        CS = 1'b1;
        checks++; if (data_out !== first) begin fails++; $display("FAIL order_rx: got %h expected %h", data_out, first); end
        result_in = first; result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        checks++; if (sds_out !== 1'b1) begin fails++; $display("FAIL order_tx0: got %b expected 1", sds_out); end
        CS = 1'b0;
        tick();
        CS = 1'b1;
        checks++; if (sds_out !== 1'b0) begin fails++; $display("FAIL order_tx1: got %b expected 0", sds_out); end
    endtask

    initial begin
        test_reset();
        test_single_rx();
        test_overrun();
        test_abort();
        test_tx();
        test_bit_order();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
